// File: rtl/board_pkg.sv
// Shared playfield geometry and enum types for move-enable generation.
//   COLS/ROWS/CELLS : board geometry, cell index = row*COLS + col
//   cell_idx_t      : 5-bit cell index
//   state_t         : scan controller states
//   dir_t           : move directions, also used as bit positions in enable nibbles
package board_pkg;

  localparam int COLS  = 4;
  localparam int ROWS  = 6;
  localparam int CELLS = COLS * ROWS;

  typedef logic [4:0] cell_idx_t;

  localparam cell_idx_t   LAST_IDX  = 5'(CELLS - 1);
  localparam cell_idx_t   COLS_IDX  = 5'(COLS);
  localparam logic [2:0]  LAST_ROW  = 3'(ROWS - 1);
  localparam logic [1:0]  LAST_COL  = 2'(COLS - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    DIR_UP    = 2'd0,
    DIR_DOWN  = 2'd1,
    DIR_LEFT  = 2'd2,
    DIR_RIGHT = 2'd3
  } dir_t;

  // COLS is 4, so row/column fall straight out of the index bits.
  function automatic logic [2:0] row_of(cell_idx_t i);
    return i[4:2];
  endfunction

  function automatic logic [1:0] col_of(cell_idx_t i);
    return i[1:0];
  endfunction

endpackage

// File: rtl/move_enable_gen_if.sv
// Request/result bundle between board-state registers, the move-enable
// generator and the enable-compare stage.
//   start, piece_mask, occ_mask : request side (master drives)
//   busy, done, valid           : status (slave drives)
//   up/down/left/right_en       : per-cell enable vectors (slave drives)
interface move_enable_gen_if;
  import board_pkg::*;

  logic             start;
  logic [CELLS-1:0] piece_mask;
  logic [CELLS-1:0] occ_mask;
  logic             busy;
  logic             done;
  logic             valid;
  logic [CELLS-1:0] up_en;
  logic [CELLS-1:0] down_en;
  logic [CELLS-1:0] left_en;
  logic [CELLS-1:0] right_en;

  modport master (
    output start, piece_mask, occ_mask,
    input  busy, done, valid, up_en, down_en, left_en, right_en
  );

  modport slave (
    input  start, piece_mask, occ_mask,
    output busy, done, valid, up_en, down_en, left_en, right_en
  );

endinterface

// File: rtl/cell_move_check.sv
// Combinational move check for a single cell.
//   piece, occ : snapshot masks of the falling piece and settled blocks
//   idx        : cell being evaluated
//   en         : enable per direction, bit position given by dir_t
// A cell outside the piece never restricts movement. For a piece cell the
// neighbour must exist and be free of settled blocks; other piece cells do
// not block because they move together.
module cell_move_check
  import board_pkg::*;
(
  input  logic [CELLS-1:0] piece,
  input  logic [CELLS-1:0] occ,
  input  cell_idx_t        idx,
  output logic [3:0]       en
);

  logic [2:0] row;
  logic [1:0] col;
  cell_idx_t  n_up;
  cell_idx_t  n_dn;
  cell_idx_t  n_lf;
  cell_idx_t  n_rt;

  always_comb begin
    row  = row_of(idx);
    col  = col_of(idx);
    // Neighbour indices may fall off the board; they are only used when
    // the matching bounds test passes.
    n_up = idx - COLS_IDX;
    n_dn = idx + COLS_IDX;
    n_lf = idx - 5'd1;
    n_rt = idx + 5'd1;

    en = '1;
    if (piece[idx]) begin
      en[DIR_UP]    = (row != 3'd0)     && !occ[n_up];
      en[DIR_DOWN]  = (row != LAST_ROW) && !occ[n_dn];
      en[DIR_LEFT]  = (col != 2'd0)     && !occ[n_lf];
      en[DIR_RIGHT] = (col != LAST_COL) && !occ[n_rt];
    end
  end

endmodule

// File: rtl/move_enable_gen.sv
// Move-enable generator: snapshots the piece and occupancy masks on start,
// walks the 24 cells one per clock and publishes four enable vectors.
//   clk, rst_n : clock (rising edge), async active-low reset
//   bus        : request masks in; busy/done/valid and enable vectors out
//
// state | meaning
// IDLE  | waiting for start; outputs hold last result
// SCAN  | evaluating cell idx, writing working vectors
// DONE  | publishing working vectors, pulsing done
module move_enable_gen
  import board_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  move_enable_gen_if.slave  bus
);

  state_t                 state_q, state_d;
  cell_idx_t              idx_q;
  logic [CELLS-1:0]       piece_q, occ_q;
  logic [3:0][CELLS-1:0]  work_q;
  logic [CELLS-1:0]       up_q, down_q, left_q, right_q;
  logic                   done_q, valid_q;
  logic [3:0]             cell_en;

  logic accept, scan_we, publish;

  cell_move_check u_check (
    .piece (piece_q),
    .occ   (occ_q),
    .idx   (idx_q),
    .en    (cell_en)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    scan_we = 1'b0;
    publish = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          accept  = 1'b1;
          state_d = ST_SCAN;
        end
      end
      ST_SCAN: begin
        scan_we = 1'b1;
        if (idx_q == LAST_IDX) state_d = ST_DONE;
      end
      ST_DONE: begin
        publish = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q   <= '0;
      piece_q <= '0;
      occ_q   <= '0;
      work_q  <= '0;
      up_q    <= '0;
      down_q  <= '0;
      left_q  <= '0;
      right_q <= '0;
      done_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      done_q <= publish;
      if (accept) begin
        piece_q <= bus.piece_mask;
        occ_q   <= bus.occ_mask;
        work_q  <= '0;
        valid_q <= 1'b0;
        idx_q   <= '0;
      end
      if (scan_we) begin
        work_q[DIR_UP][idx_q]    <= cell_en[DIR_UP];
        work_q[DIR_DOWN][idx_q]  <= cell_en[DIR_DOWN];
        work_q[DIR_LEFT][idx_q]  <= cell_en[DIR_LEFT];
        work_q[DIR_RIGHT][idx_q] <= cell_en[DIR_RIGHT];
        // Hold at the last cell rather than wrapping.
        if (idx_q != LAST_IDX) idx_q <= idx_q + 5'd1;
      end
      if (publish) begin
        up_q    <= work_q[DIR_UP];
        down_q  <= work_q[DIR_DOWN];
        left_q  <= work_q[DIR_LEFT];
        right_q <= work_q[DIR_RIGHT];
        valid_q <= 1'b1;
      end
    end
  end

  assign bus.busy     = (state_q != ST_IDLE);
  assign bus.done     = done_q;
  assign bus.valid    = valid_q;
  assign bus.up_en    = up_q;
  assign bus.down_en  = down_q;
  assign bus.left_en  = left_q;
  assign bus.right_en = right_q;

endmodule

// File: tb/tb_move_enable_gen.sv
// Scoreboard bench for move_enable_gen: stimulus pushes hand-computed
// expected vectors, a negedge monitor pops and compares on every done.
module tb_move_enable_gen;

  typedef struct packed {
    logic [23:0] up;
    logic [23:0] down;
    logic [23:0] left;
    logic [23:0] right;
  } exp_t;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  int   cyc;
  int   done_cnt;
  exp_t exp_q[$];

  move_enable_gen_if bus ();

  move_enable_gen dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [23:0] act, input logic [23:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Monitor: every done must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && bus.done === 1'b1) begin
      exp_t e;
      done_cnt++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done at cycle %0d expected none", cyc);
      end else begin
        e = exp_q.pop_front();
        chk("up_en",    bus.up_en,    e.up);
        chk("down_en",  bus.down_en,  e.down);
        chk("left_en",  bus.left_en,  e.left);
        chk("right_en", bus.right_en, e.right);
        chk("valid_at_done", {23'd0, bus.valid}, 24'd1);
      end
    end
  end

  task automatic run_eval(input logic [23:0] p, input logic [23:0] o, input exp_t e);
    int k;
    @(negedge clk);
    bus.start      = 1'b1;
    bus.piece_mask = p;
    bus.occ_mask   = o;
    exp_q.push_back(e);
    @(negedge clk);
    bus.start      = 1'b0;
    // Scramble inputs after accept; result must come from the snapshot.
    bus.piece_mask = 24'hFFFFFF;
    bus.occ_mask   = 24'hFFFFFF;
    chk("busy_after_accept",  {23'd0, bus.busy},  24'd1);
    chk("valid_after_accept", {23'd0, bus.valid}, 24'd0);
    for (k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (k == 24) chk("busy_in_done_state", {23'd0, bus.busy}, 24'd1);
      if (bus.done === 1'b1) break;
    end
    chk("latency", 24'(k), 24'd25);
    @(negedge clk);
    chk("done_one_cycle", {23'd0, bus.done},  24'd0);
    chk("valid_holds",    {23'd0, bus.valid}, 24'd1);
  endtask

  initial begin
    int base;
    int k;
    int n;
    int t[3];
    checks = 0; errors = 0; cyc = 0; done_cnt = 0;
    rst_n = 1'b0;
    bus.start = 1'b0;
    bus.piece_mask = '0;
    bus.occ_mask = '0;
    #1;
    chk("rst_busy",  {23'd0, bus.busy},  24'd0);
    chk("rst_done",  {23'd0, bus.done},  24'd0);
    chk("rst_valid", {23'd0, bus.valid}, 24'd0);
    chk("rst_up",    bus.up_en,   24'h000000);
    chk("rst_down",  bus.down_en, 24'h000000);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Piece at cell 0, free board.
    run_eval(24'h000001, 24'h000000, '{24'hFFFFFE, 24'hFFFFFF, 24'hFFFFFE, 24'hFFFFFF});
    // Piece at cell 21 (bottom row).
    run_eval(24'h200000, 24'h000000, '{24'hFFFFFF, 24'hDFFFFF, 24'hFFFFFF, 24'hFFFFFF});
    // Piece at cell 5, settled block directly below at cell 9.
    run_eval(24'h000020, 24'h000200, '{24'hFFFFFF, 24'hFFFFDF, 24'hFFFFFF, 24'hFFFFFF});
    // Piece at cells 0,1; settled at 2 (right of 1) and 4 (below 0).
    run_eval(24'h000003, 24'h000014, '{24'hFFFFFC, 24'hFFFFFE, 24'hFFFFFE, 24'hFFFFFD});

    // start during scan with different masks is ignored.
    base = done_cnt;
    @(negedge clk);
    bus.start = 1'b1; bus.piece_mask = 24'h000001; bus.occ_mask = 24'h000000;
    exp_q.push_back('{24'hFFFFFE, 24'hFFFFFF, 24'hFFFFFE, 24'hFFFFFF});
    @(negedge clk);
    bus.start = 1'b0;
    repeat (9) @(negedge clk);
    bus.start = 1'b1; bus.piece_mask = 24'h200000; bus.occ_mask = 24'h000010;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (40) @(negedge clk);
    chk("single_done_when_start_busy", 24'(done_cnt - base), 24'd1);

    // start held high: back-to-back evaluations.
    @(negedge clk);
    bus.start = 1'b1; bus.piece_mask = 24'h000020; bus.occ_mask = 24'h000200;
    repeat (3) exp_q.push_back('{24'hFFFFFF, 24'hFFFFDF, 24'hFFFFFF, 24'hFFFFFF});
    n = 0;
    for (k = 0; k < 120 && n < 3; k++) begin
      @(negedge clk);
      if (k == 1) chk("held_valid_low", {23'd0, bus.valid}, 24'd0);
      if (bus.done === 1'b1) begin
        t[n] = cyc;
        n++;
        if (n == 3) bus.start = 1'b0;
        else if (n == 1) begin
          @(negedge clk);
          k++;
          chk("held_retrigger_busy",  {23'd0, bus.busy},  24'd1);
          chk("held_retrigger_valid", {23'd0, bus.valid}, 24'd0);
        end
      end
    end
    bus.start = 1'b0;
    chk("held_done_count", 24'(n), 24'd3);
    if (n == 3) begin
      chk("held_period_1", 24'(t[1] - t[0]), 24'd26);
      chk("held_period_2", 24'(t[2] - t[1]), 24'd26);
    end
    repeat (30) @(negedge clk);

    // Reset in the middle of a scan aborts with no result.
    @(negedge clk);
    bus.start = 1'b1; bus.piece_mask = 24'h000001; bus.occ_mask = 24'h000000;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_busy",  {23'd0, bus.busy},  24'd0);
    chk("midrst_valid", {23'd0, bus.valid}, 24'd0);
    chk("midrst_up",    bus.up_en,    24'h000000);
    chk("midrst_down",  bus.down_en,  24'h000000);
    chk("midrst_left",  bus.left_en,  24'h000000);
    chk("midrst_right", bus.right_en, 24'h000000);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    base = done_cnt;
    repeat (3) @(negedge clk);
    chk("postrst_busy",  {23'd0, bus.busy},  24'd0);
    chk("postrst_valid", {23'd0, bus.valid}, 24'd0);
    repeat (30) @(negedge clk);
    chk("postrst_no_done", 24'(done_cnt - base), 24'd0);
    chk("scoreboard_drained", 24'(exp_q.size()), 24'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
